// File: rtl/data_read_axi_regs.sv
// data_read_axi_regs: AXI4-Lite register file (CR/LEN/SR[/IER]) for NUM_CH data_read channels
// Ports: S_AXI_* AXI4-Lite slave (S_AXI_ACLK, async active-low S_AXI_ARESETN);
//        cr_start/cr_enable/len_out to the engines, sts_busy/sts_done from them, irq out.
// Map per channel (ch = addr[ADDR_W-1:4]): 0x0 CR, 0x4 LEN, 0x8 SR, 0xC IER.
// Define DATA_READ_IRQ_EN to map IER and drive irq; otherwise IER is SLVERR and irq is 0.
module data_read_axi_regs #(
   parameter int          NUM_CH  = 2,
   parameter int          ADDR_W  = 8,
   parameter logic [31:0] LEN_RST = 32'h0000_0100
) (
   input  logic                S_AXI_ACLK,
   input  logic                S_AXI_ARESETN,
   input  logic [31:0]         S_AXI_AWADDR,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [31:0]         S_AXI_WDATA,
   input  logic [3:0]          S_AXI_WSTRB,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [31:0]         S_AXI_ARADDR,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [31:0]         S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY,
   output logic [NUM_CH-1:0]   cr_start,
   output logic [NUM_CH-1:0]   cr_enable,
   output logic [32*NUM_CH-1:0] len_out,
   input  logic [NUM_CH-1:0]   sts_busy,
   input  logic [NUM_CH-1:0]   sts_done,
   output logic                irq
);
`ifdef DATA_READ_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
   w_state_t w_state;
   r_state_t r_state;
   logic [NUM_CH-1:0] done, ier, w1c;
   logic [31:0] len [NUM_CH];
   logic [CW-1:0] wi, ri;
   logic [1:0] wreg, rreg;
   logic werr, rerr;
   logic [31:0] rd_val;
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWADDR[31:ADDR_W], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:ADDR_W], S_AXI_ARADDR[1:0]};
   for (genvar g = 0; g < NUM_CH; g++) begin : g_len
      assign len_out[32*g +: 32] = len[g];
   end
   // Channel compare is one bit wider than the field so NUM_CH == 2**field_width still fits.
   always_comb begin
      wi = S_AXI_AWADDR[4 +: CW];
      ri = S_AXI_ARADDR[4 +: CW];
      wreg = S_AXI_AWADDR[3:2];
      rreg = S_AXI_ARADDR[3:2];
      werr = {1'b0, S_AXI_AWADDR[ADDR_W-1:4]} >= (ADDR_W-3)'(NUM_CH) || (wreg == 2'd3 && !IRQ);
      rerr = {1'b0, S_AXI_ARADDR[ADDR_W-1:4]} >= (ADDR_W-3)'(NUM_CH) || (rreg == 2'd3 && !IRQ);
      rd_val = rerr        ? 32'h0 :
               rreg == 2'd0 ? {30'h0, cr_enable[ri], 1'b0} :
               rreg == 2'd1 ? len[ri] :
               rreg == 2'd2 ? {30'h0, done[ri], sts_busy[ri]} :
                              {30'h0, ier[ri], 1'b0};
      w1c = '0;
      if (w_state == W_ACK && !werr && wreg == 2'd2 && S_AXI_WSTRB[0] && S_AXI_WDATA[1])
         w1c[wi] = 1'b1;
   end
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state <= W_IDLE;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY <= 1'b0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP <= 2'b00;
         cr_start <= '0;
         cr_enable <= '0;
         ier <= '0;
         done <= '0;
         for (int i = 0; i < NUM_CH; i++) len[i] <= LEN_RST;
      end else begin
         cr_start <= '0;
         // A new completion in the same cycle as a W1C keeps DONE set.
         done <= sts_done | (done & ~w1c);
         case (w_state)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
               S_AXI_AWREADY <= 1'b1;
               S_AXI_WREADY <= 1'b1;
               w_state <= W_ACK;
            end
            W_ACK: begin
               S_AXI_AWREADY <= 1'b0;
               S_AXI_WREADY <= 1'b0;
               S_AXI_BVALID <= 1'b1;
               S_AXI_BRESP <= werr ? 2'b10 : 2'b00;
               w_state <= W_RESP;
               if (!werr) begin
                  // START only fires when the same write leaves ENABLE set.
                  if (wreg == 2'd0 && S_AXI_WSTRB[0]) begin
                     cr_enable[wi] <= S_AXI_WDATA[1];
                     cr_start[wi] <= S_AXI_WDATA[0] & S_AXI_WDATA[1];
                  end
                  if (wreg == 2'd1)
                     for (int b = 0; b < 4; b++)
                        if (S_AXI_WSTRB[b]) len[wi][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                  if (wreg == 2'd3 && S_AXI_WSTRB[0]) ier[wi] <= S_AXI_WDATA[1];
               end
            end
            W_RESP: if (S_AXI_BREADY) begin
               S_AXI_BVALID <= 1'b0;
               w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA <= 32'h0;
         S_AXI_RRESP <= 2'b00;
      end else begin
         case (r_state)
            R_IDLE: if (S_AXI_ARVALID) begin
               S_AXI_ARREADY <= 1'b1;
               r_state <= R_ACK;
            end
            R_ACK: begin
               S_AXI_ARREADY <= 1'b0;
               S_AXI_RDATA <= rd_val;
               S_AXI_RRESP <= rerr ? 2'b10 : 2'b00;
               S_AXI_RVALID <= 1'b1;
               r_state <= R_DATA;
            end
            R_DATA: if (S_AXI_RREADY) begin
               S_AXI_RVALID <= 1'b0;
               r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
`ifdef DATA_READ_IRQ_EN
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
      if (!S_AXI_ARESETN) irq <= 1'b0;
      else irq <= |(done & ier);
`else
   assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_data_read_axi_regs.sv
// tb_data_read_axi_regs: directed self-checking bench for data_read_axi_regs (NUM_CH = 2)
module tb_data_read_axi_regs;
`ifdef DATA_READ_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif
   logic        S_AXI_ACLK = 1'b0;
   logic        S_AXI_ARESETN = 1'b0;
   logic [31:0] S_AXI_AWADDR = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [31:0] S_AXI_ARADDR = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [1:0]  cr_start, cr_enable;
   logic [63:0] len_out;
   logic [1:0]  sts_busy = '0;
   logic [1:0]  sts_done = '0;
   logic        irq;
   int n_vec = 0;
   int n_err = 0;
   int start_cnt [2] = '{0, 0};
   logic [1:0] st;

   data_read_axi_regs #(.NUM_CH(2), .ADDR_W(8), .LEN_RST(32'h0000_0100)) dut (
      .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .cr_start(cr_start),
      .cr_enable(cr_enable), .len_out(len_out), .sts_busy(sts_busy), .sts_done(sts_done), .irq(irq)
   );

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   always @(negedge S_AXI_ACLK)
      for (int i = 0; i < 2; i++) if (cr_start[i]) start_cnt[i]++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   // Full write; done_at_ack drives sts_done during the W_ACK cycle, st returns cr_start in the first W_RESP cycle.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input int hold_b,
                            input logic [1:0] done_at_ack, output logic [1:0] st_o);
      int n = 0;
      S_AXI_AWADDR = a;
      S_AXI_WDATA = d;
      S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = (hold_b == 0);
      do begin tick(); n++; end while (!S_AXI_AWREADY && n < 20);
      check("w_handshake", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
      sts_done = done_at_ack;
      tick();
      sts_done = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID = 1'b0;
      st_o = cr_start;
      check("awready_drop", S_AXI_AWREADY, 0);
      check("bvalid", S_AXI_BVALID, 1);
      check("bresp", S_AXI_BRESP, exp_resp);
      for (int i = 0; i < hold_b; i++) begin
         tick();
         check("bvalid_hold", S_AXI_BVALID, 1);
         check("bresp_hold", S_AXI_BRESP, exp_resp);
      end
      S_AXI_BREADY = 1'b1;
      tick();
      check("bvalid_drop", S_AXI_BVALID, 0);
   endtask

   task automatic axi_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
      int n = 0;
      S_AXI_ARADDR = a;
      S_AXI_ARVALID = 1'b1;
      S_AXI_RREADY = 1'b1;
      do begin tick(); n++; end while (!S_AXI_ARREADY && n < 20);
      check({tag, "_arready"}, S_AXI_ARREADY, 1);
      tick();
      S_AXI_ARVALID = 1'b0;
      check({tag, "_rvalid"}, S_AXI_RVALID, 1);
      check({tag, "_rdata"}, S_AXI_RDATA, exp_d);
      check({tag, "_rresp"}, S_AXI_RRESP, exp_r);
      tick();
      check({tag, "_rvalid_drop"}, S_AXI_RVALID, 0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
      check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
      check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
      check("rst_rdata", S_AXI_RDATA, 32'h0);
      check("rst_cr", {cr_start, cr_enable}, 4'h0);
      check("rst_len", len_out, 64'h0000_0100_0000_0100);
      check("rst_irq", irq, 0);
      S_AXI_ARESETN = 1'b1;
      tick();
      axi_read("ch0_cr", 32'h00, 32'h0, 2'b00);
      axi_read("ch0_len", 32'h04, 32'h100, 2'b00);
      axi_read("ch0_sr", 32'h08, 32'h0, 2'b00);

      axi_write(32'h10, 32'h2, 4'hF, 2'b00, 0, 2'b00, st);
      check("ch1_en_start", st, 2'b00);
      check("ch1_enable", cr_enable, 2'b10);
      axi_write(32'h10, 32'h3, 4'hF, 2'b00, 0, 2'b00, st);
      check("ch1_start_pulse", st, 2'b10);
      tick();
      check("ch1_start_cnt", start_cnt[1], 1);
      check("ch1_start_low", cr_start, 2'b00);
      axi_read("ch1_cr", 32'h10, 32'h2, 2'b00);

      axi_write(32'h00, 32'h1, 4'hF, 2'b00, 0, 2'b00, st);
      check("ch0_no_pulse", st, 2'b00);
      check("ch0_start_cnt", start_cnt[0], 0);
      axi_write(32'h04, 32'hAABB_CCDD, 4'b0101, 2'b00, 0, 2'b00, st);
      check("ch0_len_out", len_out[31:0], 32'h00BB_01DD);
      axi_read("ch0_len_strb", 32'h04, 32'h00BB_01DD, 2'b00);

      sts_busy = 2'b10;
      axi_read("ch1_sr_busy", 32'h18, 32'h1, 2'b00);
      sts_busy = 2'b00;

      sts_done = 2'b01;
      tick();
      sts_done = 2'b00;
      axi_read("ch0_sr_done", 32'h08, 32'h2, 2'b00);
      axi_write(32'h08, 32'h2, 4'hF, 2'b00, 0, 2'b01, st);
      axi_read("ch0_sr_setwins", 32'h08, 32'h2, 2'b00);
      axi_write(32'h08, 32'h2, 4'hF, 2'b00, 0, 2'b00, st);
      axi_read("ch0_sr_w1c", 32'h08, 32'h0, 2'b00);

      axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 5, 2'b00, st);
      check("bad_no_pulse", st, 2'b00);
      axi_read("bad_rd", 32'h40, 32'h0, 2'b10);
      check("bad_enable", cr_enable, 2'b10);
      check("bad_len", len_out, 64'h0000_0100_00BB_01DD);

      axi_write(32'h1C, 32'h2, 4'hF, IRQ_ON ? 2'b00 : 2'b10, 0, 2'b00, st);
      axi_read("ch1_ier", 32'h1C, IRQ_ON ? 32'h2 : 32'h0, IRQ_ON ? 2'b00 : 2'b10);
      sts_done = 2'b10;
      tick();
      sts_done = 2'b00;
      check("irq_not_yet", irq, 0);
      tick();
      check("irq_set", irq, IRQ_ON);
      axi_write(32'h18, 32'h2, 4'hF, 2'b00, 0, 2'b00, st);
      check("irq_clr", irq, 0);

      S_AXI_AWADDR = 32'h10;
      S_AXI_WDATA = 32'h3;
      S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID = 1'b1;
      for (int n = 0; n < 20 && !S_AXI_AWREADY; n++) tick();
      check("mid_ack", S_AXI_AWREADY, 1);
      S_AXI_ARESETN = 1'b0;
      #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID = 1'b0;
      check("mid_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b000);
      check("mid_cr", {cr_start, cr_enable}, 4'h0);
      check("mid_len", len_out, 64'h0000_0100_0000_0100);
      repeat (2) tick();
      check("mid_start_cnt", start_cnt[1], 1);
      S_AXI_ARESETN = 1'b1;
      tick();
      axi_read("post_rst_cr", 32'h10, 32'h0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/data_read_axi_regs.md
Name: data_read_axi_regs

Overview:
- AXI4-Lite slave register file for the data_read peripheral.
- Generalised to NUM_CH independent read channels, each with:
  - a control register carrying a START strobe and an ENABLE level,
  - a 32-bit transfer-length register,
  - a status register with a sticky DONE bit.
- Implements full write and read channels with byte strobes and SLVERR decoding.
- Sits between the AXI interconnect and the per-channel data_read engines.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- ADDR_W, 8, decoded low address bits; must satisfy ADDR_W >= 4 + clog2(NUM_CH).
- LEN_RST, 32'h0000_0100, reset value of every LEN register.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  32  write address
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake
- S_AXI_BRESP  out  2  write response, 00 OKAY / 10 SLVERR
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake
- S_AXI_ARADDR  in  32  read address
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake
- cr_start  out  NUM_CH  one-cycle START pulse per channel
- cr_enable  out  NUM_CH  ENABLE level per channel
- len_out  out  32*NUM_CH  LEN registers; channel i occupies bits [32i+31:32i]
- sts_busy  in  NUM_CH  engine busy, level, synchronous to ACLK
- sts_done  in  NUM_CH  engine completion pulse
- irq  out  1  interrupt; exists only with the optional feature, tied 0 otherwise

Behaviour:
- Reset is S_AXI_ARESETN, asynchronous, active-low; clock is S_AXI_ACLK. Reset values:
  - all READY/VALID outputs 0; BRESP, RRESP, RDATA 0
  - cr_start 0, cr_enable 0, len_out = LEN_RST per channel, DONE 0, IER 0, irq 0
- Address decode uses addr[ADDR_W-1:0]; addr[1:0] ignored.
  - Channel index ch = addr[ADDR_W-1:4].
  - Register select reg = addr[3:2]: 0 CR, 1 LEN, 2 SR, 3 IER (optional).
  - ch >= NUM_CH, or an unmapped reg -> SLVERR; write has no effect, read returns 0.
- CR register:
  - bit0 START: write-1 produces a cr_start[ch] pulse only if ENABLE, after this write, is 1; otherwise ignored. START reads 0.
  - bit1 ENABLE: RW.
  - Other bits read 0.
- LEN register: RW, 32 bits; each byte is updated only where its WSTRB bit is 1.
- SR register:
  - bit0 BUSY = sts_busy[ch], read-only.
  - bit1 DONE: sticky, set by sts_done[ch], cleared by writing 1 (W1C).
  - If a set and a W1C occur in the same cycle, set wins.
- WSTRB[0] gates the CR, SR and IER updates.
- Write FSM:
  - W_IDLE: AWVALID && WVALID -> W_ACK. A lone AWVALID or WVALID waits.
  - W_ACK: AWREADY = WREADY = 1 for exactly this cycle; registers update at its clock edge; cr_start pulses high in the following cycle -> W_RESP.
  - W_RESP: BVALID = 1 with BRESP held stable; leaves to W_IDLE on BREADY.
- Read FSM:
  - R_IDLE: ARVALID -> R_ACK.
  - R_ACK: ARREADY = 1 for one cycle; RDATA and RRESP are captured -> R_DATA.
  - R_DATA: RVALID = 1 with RDATA held stable; leaves to R_IDLE on RREADY.
- Read and write FSMs run independently. A read captured in the same cycle as a write update returns the pre-write value.
- Back-to-back transactions: minimum 3 cycles per write and 3 cycles per read when the master holds READY high.
- Reset mid-transaction aborts to IDLE with all outputs at reset values; no pulse is emitted.

Optional Feature:
- Macro: DATA_READ_IRQ_EN.
- With the macro defined:
  - IER (reg 3) is RW; bit1 enables the DONE interrupt.
  - irq = OR over channels of (DONE & IER[1]), registered, 1 cycle after DONE sets.
- Without the macro:
  - reg 3 is unmapped (SLVERR, reads 0).
  - irq is constant 0.

Test Plan:
- Reset, then read CR/LEN/SR of ch0 -> 0x0, 0x100, 0x0, all OKAY; all outputs at reset values.
- Write ch1 CR = 0x2, then ch1 CR = 0x3 -> cr_enable[1] = 1; exactly one cr_start[1] pulse, 1 cycle after the W_ACK cycle; CR reads 0x2.
- Write ch0 CR = 0x1 with ENABLE = 0 -> no pulse, BRESP OKAY. Write ch0 LEN = 0xAABBCCDD with WSTRB = 0b0101 -> LEN reads 0x00BB01DD.
- Pulse sts_done[0], read SR -> 0x2. Write SR = 0x2 in the same cycle as a new sts_done[0] -> DONE stays 1.
- Write/read address 0x40 with NUM_CH = 2 -> SLVERR, RDATA 0, no register changes. Hold BREADY low 5 cycles -> BVALID and BRESP stable throughout.
- With DATA_READ_IRQ_EN: IER ch1 = 0x2, pulse sts_done[1] -> irq = 1 one cycle later; W1C of DONE -> irq = 0. Without the macro, irq stays 0.
